// File: rtl/nios_solo_onchip_mem_arbiter_pkg.sv
// Shared types and helpers for the two-master on-chip RAM arbiter.
package nios_solo_mem_arb_pkg;

  // Top-level sequencing: clear the RAM first, then serve masters.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Master identifiers, also used as the round-robin history value.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Two-way round-robin pick: a lone requester always wins; on a conflict
  // the master that did not win last time is chosen.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g[0] = req[0] & (~req[1] | (last == M1));
    g[1] = req[1] & (~req[0] | (last == M0));
    return g;
  endfunction

endpackage

// File: rtl/nios_solo_onchip_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a registered last-winner flag.
// Grants are combinational from the request vector and the history bit.
module rr_arb2
  import nios_solo_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // One-hot grant for this cycle.
  always_comb begin
    grant_o = rr_pick(req_i, last_grant_q);
  end

  // History only moves on a cycle that actually granted someone.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_o[1]) begin
      last_grant_d = M1;
    end else if (grant_o[0]) begin
      last_grant_d = M0;
    end
  end

  // History register; M1 after reset so m0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= M1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/nios_solo_onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters. Optionally
// fills the RAM after reset, then grants one access per cycle round-robin
// and steers the 1-cycle-latency read data back to the issuing master.
module nios_solo_onchip_mem_arbiter
  import nios_solo_mem_arb_pkg::*;
#(
  parameter int              ADDR_W         = 9,
  parameter int              DATA_W         = 32,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  // master 0 (NIOS data master)
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // master 1 (DMA / debug)
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // RAM s1 port
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int                BE_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_id_q, rd_id_d;

  logic              run_active;
  logic              clr_active;
  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              granted;
  logic              sel;
  logic [1:0]        wait_vec;
  logic [1:0]        rdv_vec;

  // Per-master request fields gathered into arrays for indexed muxing.
  logic [ADDR_W-1:0] addr_a [2];
  logic [BE_W-1:0]   be_a   [2];
  logic [DATA_W-1:0] wd_a   [2];
  logic              rd_a   [2];
  logic              wr_a   [2];

  assign addr_a[0] = m0_address;
  assign addr_a[1] = m1_address;
  assign be_a[0]   = m0_byteenable;
  assign be_a[1]   = m1_byteenable;
  assign wd_a[0]   = m0_writedata;
  assign wd_a[1]   = m1_writedata;
  assign rd_a[0]   = m0_read;
  assign rd_a[1]   = m1_read;
  assign wr_a[0]   = m0_write;
  assign wr_a[1]   = m1_write;

  // Reset forces every output to its idle value in the reset cycle itself,
  // which also drops a read whose data would have returned in that cycle.
  assign run_active = (state_q == ST_RUN) & ~reset;
  assign clr_active = (state_q == ST_CLEAR) & ~reset;

  // Masters are only seen by the arbiter once the clear has finished.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign req_vec[gi]  = (rd_a[gi] | wr_a[gi]) & run_active;
    assign wait_vec[gi] = ~(run_active & grant[gi]);
    assign rdv_vec[gi]  = rd_valid_q & ~reset & (rd_id_q == 1'(gi));
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_vec),
    .grant_o (grant)
  );

  assign granted = |grant;
  assign sel     = grant[1] ? M1 : M0;

  // Sequencer next state: walk the clear counter once, then stay in RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Sequencer state and clear counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // RAM port mux: clear writes, the granted master, or idle.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (clr_active) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = clr_cnt_q;
      mem_byteenable = '1;
      mem_writedata  = CLEAR_VALUE;
    end else if (granted) begin
      mem_chipselect = 1'b1;
      mem_write      = wr_a[sel];
      mem_address    = addr_a[sel];
      mem_byteenable = be_a[sel];
      mem_writedata  = wd_a[sel];
    end
  end

  // Remember who issued this cycle's read; a read+write pair acts as a write.
  always_comb begin
    rd_valid_d = granted & rd_a[sel] & ~wr_a[sel];
    rd_id_d    = sel;
  end

  // One-entry read-owner pipe matching the RAM's single cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= M0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdatavalid = rdv_vec[0];
  assign m1_readdatavalid = rdv_vec[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_nios_solo_onchip_mem_arbiter.sv
// Self-checking bench: RAM model on the s1 side, a behavioural reference
// model (shadow memory, last winner, pending read) checked every cycle.
module tb_nios_solo_onchip_mem_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  nios_solo_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Physical RAM: byte-enabled write, registered read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
    end
    mem_readdata <= ram[mem_address];
  end

  // Reference model state.
  int            n_asserts = 0;
  int            n_fail = 0;
  bit            m_run;
  int            m_clr;
  int            last_win;
  bit            pend_v;
  int            pend_id;
  logic [DW-1:0] pend_d;
  logic [DW-1:0] shadow [DEPTH];
  int            cur_g;
  int            rdv_cnt [2];
  bit            acc [2];
  logic [DW-1:0] last_rd [2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // One clock: check outputs on the falling edge, advance the model on the rising edge.
  task automatic step();
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [DW-1:0] d;
    bit            rd, wr;
    @(negedge clk);
    cur_g = -1;
    if (reset) begin
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_rdv0", m0_readdatavalid, 0);
      chk("rst_rdv1", m1_readdatavalid, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_we", mem_write, 0);
    end else if (!m_run) begin
      chk("clr_addr", mem_address, m_clr);
      chk("clr_cs", mem_chipselect, 1);
      chk("clr_we", mem_write, 1);
      chk("clr_be", mem_byteenable, 4'hF);
      chk("clr_data", mem_writedata, 0);
      chk("clr_wait0", m0_waitrequest, 1);
      chk("clr_wait1", m1_waitrequest, 1);
      chk("clr_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
    end else begin
      cur_g = pick(m0_read | m0_write, m1_read | m1_write, last_win);
      chk("wait0", m0_waitrequest, cur_g != 0);
      chk("wait1", m1_waitrequest, cur_g != 1);
      chk("cs", mem_chipselect, cur_g >= 0);
      chk("rdv0", m0_readdatavalid, pend_v && pend_id == 0);
      chk("rdv1", m1_readdatavalid, pend_v && pend_id == 1);
      if (pend_v) chk("rdata", (pend_id == 0) ? m0_readdata : m1_readdata, pend_d);
    end
    if (m0_readdatavalid) begin rdv_cnt[0]++; last_rd[0] = m0_readdata; end
    if (m1_readdatavalid) begin rdv_cnt[1]++; last_rd[1] = m1_readdata; end
    @(posedge clk);
    acc[0] = 0;
    acc[1] = 0;
    pend_v = 0;
    if (reset) begin
      m_run = 0; m_clr = 0; last_win = 1;
    end else if (!m_run) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_run = 1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      end
    end else if (cur_g >= 0) begin
      acc[cur_g] = 1;
      last_win = cur_g;
      a  = (cur_g == 0) ? m0_address : m1_address;
      be = (cur_g == 0) ? m0_byteenable : m1_byteenable;
      d  = (cur_g == 0) ? m0_writedata : m1_writedata;
      rd = (cur_g == 0) ? m0_read : m1_read;
      wr = (cur_g == 0) ? m0_write : m1_write;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
      end else if (rd) begin
        pend_v = 1; pend_id = cur_g; pend_d = shadow[a];
      end
    end
    #1;
  endtask

  initial begin
    bit hold0, hold1;
    int prev_g, c0, r;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    m_run = 0; m_clr = 0; last_win = 1; pend_v = 0;
    rdv_cnt[0] = 0; rdv_cnt[1] = 0; last_rd[0] = '1; last_rd[1] = '1;

    // Reset state, then full clear with m0 already requesting.
    step(); step();
    reset = 0; m0_read = 1; m0_address = 9'd5;
    for (int i = 0; i < DEPTH; i++) step();
    step();
    chk("t1_acc", acc[0], 1);
    m0_read = 0;
    step();
    chk("t1_read0", last_rd[0], 0);

    // Partial-byte write then read-back.
    m0_write = 1; m0_address = 9'h010; m0_byteenable = 4'b0101; m0_writedata = 32'hDEADBEEF;
    step();
    m0_write = 0; m0_read = 1;
    step();
    m0_read = 0;
    step();
    chk("t2_bytes", last_rd[0], 32'h00AD00EF);

    // Continuous reads from both masters alternate.
    m1_write = 1; m1_address = 9'h1FF; m1_byteenable = 4'hF; m1_writedata = 32'h12345678;
    step();
    m1_write = 0; m1_read = 1; m0_read = 1; m0_address = 9'h020;
    prev_g = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k > 0) chk("t3_alt", cur_g != prev_g, 1);
      prev_g = cur_g;
    end
    m0_read = 0; m1_read = 0;
    step();
    chk("t3_m1data", last_rd[1], 32'h12345678);

    // m1 alone: eight back-to-back reads.
    rdv_cnt[0] = 0; rdv_cnt[1] = 0;
    m1_read = 1;
    for (int k = 0; k < 8; k++) begin
      m1_address = AW'(k + 8);
      step();
      chk("t4_nowait", acc[1], 1);
    end
    m1_read = 0;
    step();
    chk("t4_cnt1", rdv_cnt[1], 8);
    chk("t4_cnt0", rdv_cnt[0], 0);

    // Random traffic; a refused request is held until accepted.
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 300; c++) begin
      if (!hold0) begin
        r = $urandom_range(0, 2);
        m0_read = (r == 1); m0_write = (r == 2);
        m0_address = AW'($urandom_range(0, 15)); m0_byteenable = 4'($urandom);
        m0_writedata = $urandom;
      end
      if (!hold1) begin
        r = $urandom_range(0, 2);
        m1_read = (r == 1); m1_write = (r == 2);
        m1_address = AW'($urandom_range(0, 15)); m1_byteenable = 4'($urandom);
        m1_writedata = $urandom;
      end
      step();
      hold0 = (m0_read | m0_write) && !acc[0];
      hold1 = (m1_read | m1_write) && !acc[1];
    end
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    step();

    // Reset in the middle of a clear restarts it from address 0.
    reset = 1; step();
    reset = 0;
    for (int i = 0; i < 100; i++) step();
    reset = 1; step();
    reset = 0;
    for (int i = 0; i < DEPTH; i++) step();
    chk("t5_run", m_run, 1);

    // Reset right after an accepted read drops its data strobe.
    m0_read = 1; m0_address = 9'h010;
    step();
    chk("t6_acc", acc[0], 1);
    c0 = rdv_cnt[0];
    reset = 1; m0_read = 0;
    step();
    chk("t6_nordv", rdv_cnt[0], c0);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) step();
    m0_read = 1; m0_address = 9'h010;
    step();
    m0_read = 0;
    step();
    chk("t6_cleared", last_rd[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
